// File: rtl/ii_rect_sum.sv
// Integral-image rectangle sum: fetches up to four II corner words and returns D - B - C + A.
// Corners on the top row or left column are skipped and treated as zero.
module ii_rect_sum #(
  parameter int II_WIDTH   = 160,
  parameter int II_HEIGHT  = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 20,
  parameter int RD_LATENCY = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rect_x,
  input  logic [7:0]        rect_y,
  input  logic [7:0]        rect_w,
  input  logic [7:0]        rect_h,
  output logic              ii_rd_en,
  output logic [ADDR_W-1:0] ii_rd_address,
  input  logic [DATA_W-1:0] ii_rddata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rect_sum
);

  typedef enum logic [2:0] {IDLE, CHECK, RD_D, RD_B, RD_C, RD_A, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          x_reg, y_reg, w_reg, h_reg;
  logic [1:0]          drain_cnt_reg;
  logic [ADDR_W-1:0]   addr_hold_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic                err_reg;
  logic [RD_LATENCY-1:0] vld_reg, neg_reg;

  logic [8:0]          x_end, y_end;
  logic                req_bad;
  logic [7:0]          col_r, col_l, row_b, row_t;
  logic [ADDR_W-1:0]   corner_addr;
  logic                corner_neg;
  logic [RD_LATENCY:0] vld_chain, neg_chain;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] row, input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 5) + ADDR_W'(col);
  endfunction

  assign x_end   = {1'b0, x_reg} + {1'b0, w_reg};
  assign y_end   = {1'b0, y_reg} + {1'b0, h_reg};
  assign req_bad = (w_reg == 8'd0) || (h_reg == 8'd0) ||
                   (x_end > 9'(II_WIDTH)) || (y_end > 9'(II_HEIGHT));

  // Wrap-around on x-1 / y-1 is harmless: those corners are never read when x or y is 0.
  assign col_r = x_reg + w_reg - 8'd1;
  assign row_b = y_reg + h_reg - 8'd1;
  assign col_l = x_reg - 8'd1;
  assign row_t = y_reg - 8'd1;

  always_ff @(posedge pclk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = req_bad ? DONE : RD_D;
      RD_D:    state_next = RD_B;
      RD_B:    state_next = RD_C;
      RD_C:    state_next = RD_A;
      RD_A:    state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == 2'(RD_LATENCY - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ii_rd_en    = 1'b0;
    corner_addr = addr_hold_reg;
    corner_neg  = 1'b0;
    case (state_reg)
      RD_D: begin ii_rd_en = 1'b1;                           corner_addr = addr_of(row_b, col_r); end
      RD_B: begin ii_rd_en = (y_reg != 8'd0);                corner_addr = addr_of(row_t, col_r); corner_neg = 1'b1; end
      RD_C: begin ii_rd_en = (x_reg != 8'd0);                corner_addr = addr_of(row_b, col_l); corner_neg = 1'b1; end
      RD_A: begin ii_rd_en = (x_reg != 8'd0) && (y_reg != 8'd0); corner_addr = addr_of(row_t, col_l); end
      default: ;
    endcase
    ii_rd_address = ii_rd_en ? corner_addr : addr_hold_reg;
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
  end

  assign err      = err_reg;
  assign rect_sum = acc_reg;

  // Read tags travel alongside the BRAM pipeline so each word is applied with its sign on arrival.
  assign vld_chain = {vld_reg, ii_rd_en};
  assign neg_chain = {neg_reg, corner_neg};

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_reg         <= '0;
      y_reg         <= '0;
      w_reg         <= '0;
      h_reg         <= '0;
      drain_cnt_reg <= '0;
      addr_hold_reg <= '0;
      acc_reg       <= '0;
      err_reg       <= 1'b0;
      vld_reg       <= '0;
      neg_reg       <= '0;
    end else begin
      vld_reg       <= vld_chain[RD_LATENCY-1:0];
      neg_reg       <= neg_chain[RD_LATENCY-1:0];
      addr_hold_reg <= ii_rd_address;
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 2'd1 : 2'd0;
      if (vld_chain[RD_LATENCY])
        acc_reg <= neg_chain[RD_LATENCY] ? acc_reg - ii_rddata : acc_reg + ii_rddata;
      if (state_reg == CHECK && req_bad)
        err_reg <= 1'b1;
      if (state_reg == IDLE && start) begin
        x_reg   <= rect_x;
        y_reg   <= rect_y;
        w_reg   <= rect_w;
        h_reg   <= rect_h;
        acc_reg <= '0;
        err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ii_rect_sum.sv
// Bench for ii_rect_sum: two instances (read latency 1 and 2) on a shared II memory model,
// results compared against direct pixel sums over the rectangle.
module tb_ii_rect_sum;
  localparam int W = 160, H = 120, AW = 15, DW = 20;

  logic pclk, rst, start0, start1;
  logic [7:0] rect_x, rect_y, rect_w, rect_h;
  logic en0, en1, busy0, busy1, done0, done1, err0, err1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rddata0, rddata1, stage1, sum0, sum1;

  logic [DW-1:0] ii_mem [0:W*H-1];
  int pix [H][W];
  int n_cmp = 0, n_bad = 0;

  logic s_en, s_busy, s_done, s_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_sum;

  ii_rect_sum #(.RD_LATENCY(1)) dut0 (
    .pclk(pclk), .rst(rst), .start(start0), .rect_x(rect_x), .rect_y(rect_y),
    .rect_w(rect_w), .rect_h(rect_h), .ii_rd_en(en0), .ii_rd_address(addr0),
    .ii_rddata(rddata0), .busy(busy0), .done(done0), .err(err0), .rect_sum(sum0));

  ii_rect_sum #(.RD_LATENCY(2)) dut1 (
    .pclk(pclk), .rst(rst), .start(start1), .rect_x(rect_x), .rect_y(rect_y),
    .rect_w(rect_w), .rect_h(rect_h), .ii_rd_en(en1), .ii_rd_address(addr1),
    .ii_rddata(rddata1), .busy(busy1), .done(done1), .err(err1), .rect_sum(sum1));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (en0) rddata0 <= ii_mem[addr0];
    if (en1) stage1 <= ii_mem[addr1];
    rddata1 <= stage1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic grab(input int k);
    if (k == 0) begin
      s_en = en0; s_addr = addr0; s_busy = busy0; s_done = done0; s_err = err0; s_sum = sum0;
    end else begin
      s_en = en1; s_addr = addr1; s_busy = busy1; s_done = done1; s_err = err1; s_sum = sum1;
    end
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) start0 = v;
    else        start1 = v;
  endtask

  // mode 0: all ones, 1: all 15, 2: random 0..15; II built as 2-D prefix sums
  task automatic load_image(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = (mode == 0) ? 1 : (mode == 1) ? 15 : int'($urandom_range(0, 15));
    for (int r = 0; r < H; r++) begin
      int row_acc = 0;
      for (int c = 0; c < W; c++) begin
        row_acc += pix[r][c];
        ii_mem[r*W+c] = DW'(row_acc + ((r > 0) ? int'(ii_mem[(r-1)*W+c]) : 0));
      end
    end
  endtask

  function automatic int ref_sum(input int x, input int y, input int w, input int h);
    int s = 0;
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++)
        s += pix[r][c];
    return s;
  endfunction

  task automatic run_req(input int k, input int x, input int y, input int w, input int h,
                         input int restart_at, input int rst_at);
    int lat, exp_done, done_cyc, done_cnt, exp_sum, obs_sum;
    int exp_addr[4], obs_addr[4];
    logic [3:0] exp_mask, obs_mask;
    logic bad, busy_ok, idle_ok, extra_rd, obs_err;
    lat = (k == 0) ? 1 : 2;
    bad = (w == 0) || (h == 0) || (x + w > W) || (y + h > H);
    if (bad && restart_at > 2) restart_at = -1;
    exp_mask = bad ? 4'b0 : {(x != 0) && (y != 0), (x != 0), (y != 0), 1'b1};
    exp_addr[0] = (y + h - 1) * W + (x + w - 1);
    exp_addr[1] = (y - 1) * W + (x + w - 1);
    exp_addr[2] = (y + h - 1) * W + (x - 1);
    exp_addr[3] = (y - 1) * W + (x - 1);
    exp_sum  = bad ? 0 : ref_sum(x, y, w, h);
    exp_done = bad ? 2 : 6 + lat;
    obs_mask = '0; obs_addr = '{default: 0};
    done_cyc = 0; done_cnt = 0; obs_sum = 0; obs_err = 1'b0;
    busy_ok = 1'b1; idle_ok = 1'b1; extra_rd = 1'b0;

    @(negedge pclk);
    rect_x = 8'(x); rect_y = 8'(y); rect_w = 8'(w); rect_h = 8'(h);
    set_start(k, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge pclk);
      if (n == 1) set_start(k, 1'b0);
      rect_x = 8'($urandom); rect_y = 8'($urandom);
      grab(k);
      if (rst_at >= 0 && n == rst_at + 1) begin
        chk("rst_en", 32'(s_en), 0);
        chk("rst_addr", 32'(s_addr), 0);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_err", 32'(s_err), 0);
        chk("rst_sum", 32'(s_sum), 0);
        chk("rst_no_done", 32'(done_cnt), 0);
        rst = 1'b0;
        $display("txn dut%0d x=%0d y=%0d w=%0d h=%0d aborted by reset at c%0d", k, x, y, w, h, rst_at);
        return;
      end
      if (s_en) begin
        if (n >= 2 && n <= 5) begin obs_mask[n-2] = 1'b1; obs_addr[n-2] = int'(s_addr); end
        else extra_rd = 1'b1;
      end
      if (done_cnt == 0 || s_done) begin
        if (!s_busy) busy_ok = 1'b0;
      end else if (s_busy) idle_ok = 1'b0;
      if (s_done) begin
        done_cnt++;
        if (done_cnt == 1) begin done_cyc = n; obs_sum = int'(s_sum); obs_err = s_err; end
      end
      if (n == restart_at) set_start(k, 1'b1);
      if (n == restart_at + 1) set_start(k, 1'b0);
      if (n == rst_at) rst = 1'b1;
    end
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("err", 32'(obs_err), 32'(bad));
    chk("sum", 32'(obs_sum), 32'(exp_sum));
    chk("sum_held", 32'(s_sum), 32'(exp_sum));
    chk("rd_mask", 32'(obs_mask), 32'(exp_mask));
    chk("rd_extra", 32'(extra_rd), 0);
    chk("busy_window", 32'(busy_ok), 1);
    chk("idle_after", 32'(idle_ok), 1);
    for (int s = 0; s < 4; s++)
      if (exp_mask[s] && obs_mask[s]) chk($sformatf("addr_slot%0d", s), 32'(obs_addr[s]), 32'(exp_addr[s]));
    $display("txn dut%0d x=%0d y=%0d w=%0d h=%0d sum=%0d/%0d err=%0d done_c%0d",
             k, x, y, w, h, obs_sum, exp_sum, obs_err, done_cyc);
  endtask

  initial begin
    int x, y, w, h, ra;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    rect_x = 8'd10; rect_y = 8'd20; rect_w = 8'd5; rect_h = 8'd4;
    load_image(0);
    repeat (2) @(negedge pclk);
    start0 = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0; start0 = 1'b0;
    @(negedge pclk);
    grab(0);
    chk("reset_en", 32'(s_en), 0);
    chk("reset_addr", 32'(s_addr), 0);
    chk("reset_busy", 32'(s_busy), 0);
    chk("reset_done", 32'(s_done), 0);
    chk("reset_err", 32'(s_err), 0);
    chk("reset_sum", 32'(s_sum), 0);
    grab(1);
    chk("reset_busy1", 32'(s_busy), 0);

    run_req(0, 10, 20, 5, 4, -1, -1);
    load_image(1);
    run_req(0, 0, 0, 160, 120, -1, -1);
    load_image(0);
    run_req(0, 0, 5, 3, 2, -1, -1);
    run_req(0, 150, 0, 20, 10, -1, -1);
    run_req(0, 10, 20, 5, 4, 3, -1);
    run_req(0, 10, 20, 5, 4, -1, 4);
    run_req(0, 10, 20, 5, 4, -1, -1);
    run_req(1, 10, 20, 5, 4, -1, -1);
    run_req(1, 0, 0, 160, 120, -1, -1);
    run_req(0, 159, 119, 1, 1, -1, -1);
    run_req(1, 5, 0, 0, 3, -1, -1);

    load_image(2);
    for (int i = 0; i < 24; i++) begin
      x = $urandom_range(0, W - 1);
      y = $urandom_range(0, H - 1);
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, W - x));
      h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, H - y));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : -1;
      run_req(i % 2, x, y, w, h, ra, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
